scan_decoder_74138: RTL
=======================

Name: scan_decoder_74138

Overview:
Parametrised, registered successor to the 74138-style 3-to-8 decoder. Decodes an SEL_W-bit select into 2**SEL_W active-low outputs, gated by the 74138 enable triple (G1, /G2A, /G2B).
Adds a mode control:
- Direct mode: registered decode of select_i.
- Scan mode: an internal counter sweeps outputs 0..last_i, holding each for a programmable dwell (display/keypad multiplexing).
Sits between control logic and multiplexed display digit drivers.

Parameters:
SEL_W, 3, select width; output count is 2**SEL_W (valid range 1..6)
DWELL_W, 8, width of dwell programming input and dwell counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
select_i  input  SEL_W  direct-mode select
g1_en_i  input  1  enable, active-high
g2a_en_n_i  input  1  enable, active-low
g2b_en_n_i  input  1  enable, active-low
mode_i  input  1  0 = direct, 1 = scan
dwell_i  input  DWELL_W  scan: cycles per channel minus 1
last_i  input  SEL_W  scan: highest channel visited before wrap
yn_o  output  2**SEL_W  decoded outputs, active-low, registered
cur_sel_o  output  SEL_W  channel currently driven low (registered)
wrap_o  output  1  one-cycle pulse on scan wrap to channel 0

Behaviour:
- Async reset (rst_i=1):
  - yn_o = all ones; cur_sel_o = 0; wrap_o = 0.
  - dwell counter = 0; state = IDLE.
  - Reset mid-operation takes effect immediately, not at the next edge.
- Enable: en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i, sampled each clock.
- Output rule, all active states: yn_o = all ones except bit cur_sel_o = 0. Exactly one bit is low.
- IDLE state: yn_o = all ones.
- FSM states: IDLE, DIRECT, SCAN. Evaluated each edge; en has priority over mode_i.
  - any state, en=0 -> IDLE.
    - yn_o = all ones next cycle.
    - Scan position and dwell counter held (pause), wrap_o = 0.
  - IDLE, en=1, mode_i=0 -> DIRECT.
  - IDLE, en=1, mode_i=1 -> SCAN.
    - Resumes at held cur_sel_o with dwell counter cleared.
  - DIRECT, en=1, mode_i=1 -> SCAN.
    - Position forced to 0, dwell counter cleared.
    - First scan cycle shows channel 0; wrap_o = 0.
  - SCAN, en=1, mode_i=0 -> DIRECT.
    - Scan position and dwell counter cleared.
- DIRECT: each edge, cur_sel_o <= select_i. yn_o updates with it. Latency 1 clock from select_i/enable to yn_o.
- SCAN, each edge:
  - If dwell_cnt == dwell_i: dwell_cnt <= 0 and the channel advances.
  - Otherwise dwell_cnt increments and the channel holds.
  - Each channel is therefore low for dwell_i+1 cycles.
  - dwell_i = 0 advances every cycle.
- SCAN advance rules:
  - If cur_sel_o >= last_i: next = 0 and wrap_o = 1 for that one cycle, aligned with cur_sel_o becoming 0.
  - Otherwise next = cur_sel_o + 1.
  - The >= comparison covers last_i lowered below the current position: wrap on the next advance.
  - last_i = 0: channel 0 held permanently; wrap_o pulses every dwell_i+1 cycles.
- Live inputs: dwell_i and last_i are sampled live each cycle.
  - Raising dwell_i above the current count extends the current channel.
  - Lowering it below the count holds the counter until it wraps through 2**DWELL_W. No early advance; counter wraps modulo 2**DWELL_W.
- wrap_o is never asserted outside SCAN.
- yn_o, cur_sel_o and wrap_o are all registered; there is no combinational input-to-output path.

Test Plan:
- Reset:
  - Stimulus: assert rst_i mid-scan, asynchronous to the clock.
  - Required: yn_o = 8'hFF, cur_sel_o = 0, wrap_o = 0 immediately.
  - After release with en=1, mode_i=0, select_i=5: yn_o = 8'hDF one edge later.
- Direct decode with enables:
  - Stimulus: sweep all 8 selects × all 8 enable combinations.
  - Required: yn_o = ~(1<<sel) only when g1=1, g2a=0, g2b=0, otherwise 8'hFF, each 1 clock after the input change.
- Scan with dwell:
  - Stimulus: mode_i=1, dwell_i=2, last_i=7.
  - Required: yn_o steps FE, FD, FB, ... 7F, each for 3 cycles, then FE again.
  - wrap_o high for exactly 1 cycle, when cur_sel_o returns to 0; period 24 cycles.
- Partial scan and last_i change:
  - Stimulus: last_i=3, dwell_i=0.
  - Required: cur_sel_o follows 0,1,2,3,0 with wrap_o every 4th cycle.
  - Then, at cur_sel_o=3, set last_i=1: the next cycle is 0 with wrap_o=1, then 0,1,0,1.
- Pause/resume:
  - Stimulus: in scan at channel 4, drive g2a_en_n_i=1 for 5 cycles.
  - Required: yn_o = FF during the pause. After re-enable, channel 4 is held for a full dwell_i+1 cycles before advancing.
- Mode switch:
  - Stimulus: scan at channel 6, set mode_i=0 with select_i=2.
  - Required: next yn_o = FB.
  - Back to mode_i=1: next yn_o = FE, wrap_o = 0.

Source files
------------

// File: rtl/scan_decoder_74138.sv
// Registered 74138-style decoder with direct and scan modes.
// Decodes a SEL_W-bit channel into 2**SEL_W active-low outputs gated by the
// G1 / /G2A / /G2B enable triple. In scan mode an internal counter walks the
// channels 0..last_i, holding each for dwell_i+1 cycles.
module scan_decoder_74138 #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    g1_en_i,
  input  logic                    g2a_en_n_i,
  input  logic                    g2b_en_n_i,
  input  logic                    mode_i,
  input  logic [DWELL_W-1:0]      dwell_i,
  input  logic [SEL_W-1:0]        last_i,
  output logic [(1<<SEL_W)-1:0]   yn_o,
  output logic [SEL_W-1:0]        cur_sel_o,
  output logic                    wrap_o
);

  localparam int NOUT = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_cur_sel;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [DWELL_W-1:0]   w_cnt_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic [NOUT-1:0]      r_yn;
  logic [NOUT-1:0]      w_yn_nxt;
  logic                 w_en;

  // Active-low one-hot: all ones except the selected channel.
  function automatic logic [NOUT-1:0] decode_n(input logic [SEL_W-1:0] sel);
    logic [NOUT-1:0] v;
    v      = {NOUT{1'b1}};
    v[sel] = 1'b0;
    return v;
  endfunction

  assign w_en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;

  // Next-state, channel, dwell and wrap decisions; enable outranks mode.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_cur_sel;
    w_cnt_nxt   = r_dwell_cnt;
    w_wrap_nxt  = 1'b0;
    if (!w_en) begin
      // Pause: position and dwell count are kept for a later resume.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mode_i) begin
            // Resume scanning at the held channel with a fresh dwell.
            w_state_nxt = ST_SCAN;
            w_cnt_nxt   = {DWELL_W{1'b0}};
          end else begin
            w_state_nxt = ST_DIRECT;
            w_sel_nxt   = select_i;
          end
        end
        ST_DIRECT: begin
          if (mode_i) begin
            w_state_nxt = ST_SCAN;
            w_sel_nxt   = {SEL_W{1'b0}};
            w_cnt_nxt   = {DWELL_W{1'b0}};
          end else begin
            w_sel_nxt   = select_i;
          end
        end
        ST_SCAN: begin
          if (!mode_i) begin
            w_state_nxt = ST_DIRECT;
            w_sel_nxt   = select_i;
            w_cnt_nxt   = {DWELL_W{1'b0}};
          end else if (r_dwell_cnt == dwell_i) begin
            w_cnt_nxt = {DWELL_W{1'b0}};
            // >= so a last_i lowered below the position wraps on this advance.
            if (r_cur_sel >= last_i) begin
              w_sel_nxt  = {SEL_W{1'b0}};
              w_wrap_nxt = 1'b1;
            end else begin
              w_sel_nxt  = r_cur_sel + SEL_W'(1);
            end
          end else begin
            // Counter wraps modulo 2**DWELL_W if dwell_i drops below it.
            w_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output pattern that the registered outputs will show next cycle.
  always_comb begin
    w_yn_nxt = {NOUT{1'b1}};
    if (w_state_nxt == ST_IDLE) begin
      w_yn_nxt = {NOUT{1'b1}};
    end else begin
      w_yn_nxt = decode_n(w_sel_nxt);
    end
  end

  // State and registered outputs, cleared immediately by async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cur_sel   <= {SEL_W{1'b0}};
      r_dwell_cnt <= {DWELL_W{1'b0}};
      r_wrap      <= 1'b0;
      r_yn        <= {NOUT{1'b1}};
    end else begin
      r_state     <= w_state_nxt;
      r_cur_sel   <= w_sel_nxt;
      r_dwell_cnt <= w_cnt_nxt;
      r_wrap      <= w_wrap_nxt;
      r_yn        <= w_yn_nxt;
    end
  end

  assign yn_o      = r_yn;
  assign cur_sel_o = r_cur_sel;
  assign wrap_o    = r_wrap;

endmodule
